pc_trace_buffer: RTL and testbench

//  Synthesisable on-chip trace of the CPU's committed PC/instruction stream into a circular buffer.

---
 rtl/pc_trace_buffer.sv | 191 +++++++++++++++++++
 tb/tb_pc_trace_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pc_trace_buffer
// Purpose  : On-chip trace of the committed PC/instruction stream into a
//            circular buffer. Software arms it. Capture stops POST_TRIG
//            captures after a PC-match trigger. The frozen window is then
//            drained oldest-first through a valid/ready read port.
// Ports    : clk, PcReSet_n (async active-low reset)
//            cap_en/pc/ins          - committed instruction tap
//            arm/clr/trig_en/trig_pc - control
//            armed/triggered/done/wrapped/count - status
//            rd_valid/rd_ready/rd_pc/rd_ins[/rd_ts] - readout
// Options  : TRACE_TIMESTAMP_EN - adds a free-running TS_W cycle counter.
//            Its value at each capture edge is stored and returned on rd_ts.
// Revision : 1.0 - initial release
// ============================================================================
module pc_trace_buffer #(
  parameter int PC_W      = 32,
  parameter int INS_W     = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
`ifdef TRACE_TIMESTAMP_EN
  ,parameter int TS_W     = 16
`endif
) (
  input  logic                      clk,
  input  logic                      PcReSet_n,
  input  logic                      cap_en,
  input  logic [PC_W-1:0]           pc,
  input  logic [INS_W-1:0]          ins,
  input  logic                      arm,
  input  logic                      clr,
  input  logic                      trig_en,
  input  logic [PC_W-1:0]           trig_pc,
  output logic                      armed,
  output logic                      triggered,
  output logic                      done,
  output logic                      wrapped,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [PC_W-1:0]           rd_pc,
  output logic [INS_W-1:0]          rd_ins
`ifdef TRACE_TIMESTAMP_EN
  ,output logic [TS_W-1:0]          rd_ts
`endif
);

  localparam int             c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_DEPTH   = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]  c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic [c_AW-1:0] c_POST   = c_AW'(POST_TRIG);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ARMED = 2'd1;
  localparam logic [1:0] c_S_POST  = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0]      r_state, w_state_nxt;
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr, r_post_cnt;
  logic [c_AW:0]   r_count, r_remaining;
  logic            r_triggered, r_wrapped;

  logic [PC_W-1:0]  r_mem_pc  [DEPTH];
  logic [INS_W-1:0] r_mem_ins [DEPTH];

  logic            w_capturing, w_wr, w_hit, w_pop;
  logic [c_AW-1:0] w_wr_ptr_nxt;
  logic [c_AW:0]   w_count_nxt;

  assign w_capturing  = (r_state == c_S_ARMED) || (r_state == c_S_POST);
  assign w_wr         = w_capturing && cap_en && !clr;
  // Matches only count while ARMED; once in POST the trigger is latched.
  assign w_hit        = (r_state == c_S_ARMED) && cap_en && trig_en && (pc == trig_pc);
  assign w_pop        = rd_valid && rd_ready;
  assign w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
  assign w_count_nxt  = (r_count == c_DEPTH) ? r_count : (r_count + c_CNT_ONE);

  // State register
  always_ff @(posedge clk or negedge PcReSet_n) begin
    if (!PcReSet_n) r_state <= c_S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (arm) w_state_nxt = c_S_ARMED;
      c_S_ARMED: if (w_hit) w_state_nxt = (POST_TRIG == 0) ? c_S_DONE : c_S_POST;
      c_S_POST:  if (cap_en && (r_post_cnt == c_PTR_ONE)) w_state_nxt = c_S_DONE;
      c_S_DONE:  if ((r_remaining == '0) || (w_pop && (r_remaining == c_CNT_ONE)))
                   w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
    if (clr) w_state_nxt = c_S_IDLE;
  end

  // Output logic; read data is gated so nothing stale shows while idle.
  always_comb begin
    armed     = w_capturing;
    done      = (r_state == c_S_DONE);
    triggered = r_triggered;
    wrapped   = r_wrapped;
    count     = r_count;
    rd_valid  = (r_state == c_S_DONE) && (r_remaining != '0);
    rd_pc     = rd_valid ? r_mem_pc[r_rd_ptr]  : '0;
    rd_ins    = rd_valid ? r_mem_ins[r_rd_ptr] : '0;
  end

  // Pointers, counters and flags
  always_ff @(posedge clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_triggered <= 1'b0;
      r_wrapped   <= 1'b0;
    end else if (clr) begin
      r_count     <= '0;
      r_remaining <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (arm) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
          end
        end
        c_S_ARMED, c_S_POST: begin
          if (cap_en) begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            if (r_count == c_DEPTH) r_wrapped <= 1'b1;
          end
          if (w_hit) begin
            r_triggered <= 1'b1;
            r_post_cnt  <= c_POST;
          end
          if ((r_state == c_S_POST) && cap_en) r_post_cnt <= r_post_cnt - c_PTR_ONE;
          // Oldest entry sits count slots behind the post-write pointer; a full
          // buffer (count==DEPTH) truncates to an offset of zero.
          if (w_state_nxt == c_S_DONE) begin
            r_rd_ptr    <= w_wr_ptr_nxt - w_count_nxt[c_AW-1:0];
            r_remaining <= w_count_nxt;
          end
        end
        default: begin
          if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + c_PTR_ONE;
            r_remaining <= r_remaining - c_CNT_ONE;
          end
        end
      endcase
    end
  end

  // Trace storage
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_pc[r_wr_ptr]  <= pc;
      r_mem_ins[r_wr_ptr] <= ins;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  always_ff @(posedge clk or negedge PcReSet_n) begin
    if (!PcReSet_n) r_ts <= '0;
    else            r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem_ts[r_wr_ptr] <= r_ts;
  end

  assign rd_ts = rd_valid ? r_mem_ts[r_rd_ptr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_trace_buffer
// Purpose  : Directed self-checking bench for pc_trace_buffer (DEPTH=16,
//            POST_TRIG=8). Stream k: pc=0x3000+4k, ins=k.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trace_buffer;

  logic        clk = 1'b0;
  logic        PcReSet_n;
  logic        cap_en, arm, clr, trig_en, rd_ready;
  logic [31:0] pc, ins, trig_pc;
  logic        armed, triggered, done, wrapped, rd_valid;
  logic [4:0]  count;
  logic [31:0] rd_pc, rd_ins;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_trace_buffer #(.PC_W(32), .INS_W(32), .DEPTH(16), .POST_TRIG(8)) dut (
    .clk(clk), .PcReSet_n(PcReSet_n), .cap_en(cap_en), .pc(pc), .ins(ins),
    .arm(arm), .clr(clr), .trig_en(trig_en), .trig_pc(trig_pc),
    .armed(armed), .triggered(triggered), .done(done), .wrapped(wrapped),
    .count(count), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_ins(rd_ins)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  // Inputs change on negedge; outputs are sampled on negedge before changes.
  task automatic do_arm();
    arm = 1'b1; @(negedge clk); arm = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  // Feed stream k=0.. every cycle until done or k exceeds maxk.
  task automatic run_stream(input logic [31:0] tpc, input int maxk, output int lastk);
    int k;
    k = 0; lastk = -1;
    trig_pc = tpc; trig_en = 1'b1;
    while (k <= maxk && !done) begin
      cap_en = 1'b1; pc = 32'h3000 + 32'(4*k); ins = 32'(k);
      @(negedge clk);
      lastk = k; k++;
    end
    cap_en = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if ({armed,triggered,done,wrapped,rd_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b want=00000", {armed,triggered,done,wrapped,rd_valid}); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
    n_cmp++; if (rd_pc !== 32'h0) begin n_bad++; $display("FAIL reset_rd_pc got=%h want=0", rd_pc); end
    PcReSet_n = 1'b1;
    @(negedge clk);
    do_arm();
    n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL arm_accept got=%b want=1", armed); end
    do_clr();
  endtask

  task automatic test_wrap();
    int lastk;
    do_arm();
    run_stream(32'h3040, 100, lastk);
    n_cmp++; if (lastk !== 24) begin n_bad++; $display("FAIL wrap_lastk got=%0d want=24", lastk); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL wrap_count got=%0d want=16", count); end
    n_cmp++; if ({done,wrapped,triggered,armed} !== 4'b1110) begin
      n_bad++; $display("FAIL wrap_flags got=%b want=1110", {done,wrapped,triggered,armed}); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rd_valid !== 1'b1 || rd_pc !== 32'h3024 + 32'(4*i) || rd_ins !== 32'(9+i)) begin
        n_bad++; $display("FAIL wrap_entry%0d got v=%b pc=%h ins=%0d want v=1 pc=%h ins=%0d",
                          i, rd_valid, rd_pc, rd_ins, 32'h3024 + 32'(4*i), 9+i); end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_cmp++; if ({done,armed,rd_valid} !== 3'b000) begin
      n_bad++; $display("FAIL wrap_idle got=%b want=000", {done,armed,rd_valid}); end
  endtask

  task automatic test_nowrap();
    int lastk, n;
    do_arm();
    run_stream(32'h3008, 100, lastk);
    n_cmp++; if (lastk !== 10) begin n_bad++; $display("FAIL nowrap_lastk got=%0d want=10", lastk); end
    n_cmp++; if (count !== 5'd11 || wrapped !== 1'b0) begin
      n_bad++; $display("FAIL nowrap_cnt got=%0d/%b want=11/0", count, wrapped); end
    n_cmp++; if (rd_pc !== 32'h3000) begin n_bad++; $display("FAIL nowrap_first got=%h want=3000", rd_pc); end
    rd_ready = 1'b1; n = 0;
    while (n < 10 && rd_valid) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 10 || rd_pc !== 32'h3028) begin
      n_bad++; $display("FAIL nowrap_last got n=%0d pc=%h want n=10 pc=3028", n, rd_pc); end
    @(negedge clk); rd_ready = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL nowrap_end got v=%b d=%b want 0/0", rd_valid, done); end
  endtask

  task automatic test_stall();
    int lastk;
    do_arm();
    run_stream(32'h3040, 100, lastk);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rd_valid !== 1'b1 || rd_pc !== 32'h3024) begin
        n_bad++; $display("FAIL stall_hold%0d got v=%b pc=%h want v=1 pc=3024", i, rd_valid, rd_pc); end
      @(negedge clk);
    end
    rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    n_cmp++; if (rd_pc !== 32'h3028) begin n_bad++; $display("FAIL stall_next got=%h want=3028", rd_pc); end
    do_clr();
    n_cmp++; if (done !== 1'b0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_clr got d=%b v=%b want 0/0", done, rd_valid); end
  endtask

  task automatic test_clr();
    int lastk;
    do_arm();
    run_stream(32'h3008, 6, lastk);
    n_cmp++; if ({armed,triggered,done} !== 3'b110 || count !== 5'd7) begin
      n_bad++; $display("FAIL clr_pre got=%b cnt=%0d want=110 cnt=7", {armed,triggered,done}, count); end
    do_clr();
    n_cmp++; if ({armed,triggered,done,rd_valid} !== 4'b0000 || count !== 5'd0) begin
      n_bad++; $display("FAIL clr_post got=%b cnt=%0d want=0000 cnt=0", {armed,triggered,done,rd_valid}, count); end
    arm = 1'b1; clr = 1'b1; @(negedge clk); arm = 1'b0; clr = 1'b0;
    n_cmp++; if (armed !== 1'b0) begin n_bad++; $display("FAIL clr_beats_arm got=%b want=0", armed); end
  endtask

  task automatic test_async_reset();
    int lastk;
    do_arm();
    run_stream(32'h3040, 100, lastk);
    #2 PcReSet_n = 1'b0;
    #1;
    n_cmp++; if ({done,rd_valid} !== 2'b00 || count !== 5'd0) begin
      n_bad++; $display("FAIL areset got d=%b v=%b cnt=%0d want 0/0/0", done, rd_valid, count); end
    @(negedge clk); PcReSet_n = 1'b1; @(negedge clk);
    do_arm();
    n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL areset_rearm got=%b want=1", armed); end
    run_stream(32'h3008, 100, lastk);
    n_cmp++; if (lastk !== 10 || count !== 5'd11) begin
      n_bad++; $display("FAIL areset_run got k=%0d cnt=%0d want 10/11", lastk, count); end
    do_clr();
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] prev, dlt;
    int k, n;
    do_arm();
    trig_pc = 32'h3008; trig_en = 1'b1; k = 0; n = 0;
    while (!done && n < 60) begin
      if (k == 6 && n == 6) begin cap_en = 1'b0; repeat (3) @(negedge clk); n = 9; end
      cap_en = 1'b1; pc = 32'h3000 + 32'(4*k); ins = 32'(k);
      @(negedge clk); k++; n++;
    end
    cap_en = 1'b0;
    rd_ready = 1'b1;
    prev = rd_ts;
    @(negedge clk);
    for (int i = 1; i < 11; i++) begin
      dlt = rd_ts - prev;
      n_cmp++; if (dlt !== ((i == 6) ? 16'd4 : 16'd1)) begin
        n_bad++; $display("FAIL ts_delta%0d got=%0d want=%0d", i, dlt, (i == 6) ? 4 : 1); end
      prev = rd_ts;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    do_clr();
  endtask
`endif

  initial begin
    PcReSet_n = 1'b0; cap_en = 1'b0; arm = 1'b0; clr = 1'b0; trig_en = 1'b0;
    rd_ready = 1'b0; pc = '0; ins = '0; trig_pc = '0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_nowrap();
    test_stall();
    test_clr();
    test_async_reset();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
